// File: rtl/diff_freq_serial_in.sv
// diff_freq_serial_in: captures a serial bitstream with its per-bit strobe.
// Each bit is classified as high- or low-speed from the strobe interval.
// The frame is then streamed to a UART TX as data bytes, speed bytes and a
// status byte ({overflow, bit count}).
// Optional feature macro: DIFF_FREQ_SERIAL_IN_TIMEOUT_EN closes a frame after
// TIMEOUT_CYCLES without a bit or done tick.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_serial_in       serial data, sampled with i_bit_tick
//   i_bit_tick        first cycle of each bit
//   i_done_tick       end of transmitted frame
//   o_tx_data         byte for UART TX (held until the next byte)
//   o_tx_start        one-cycle start pulse for UART TX
//   i_tx_done_tick    UART TX finished the current byte
//   o_busy            high while streaming the frame
//   o_frame_done_tick one-cycle pulse after the last byte completes
module diff_freq_serial_in #(
    parameter int unsigned DATA_BIT        = 32,
    parameter int unsigned CNT_BIT         = 16,
    parameter int unsigned SPEED_THRESHOLD = 12,
    parameter int unsigned TIMEOUT_CYCLES  = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_serial_in,
    input  logic       i_bit_tick,
    input  logic       i_done_tick,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_done_tick,
    output logic       o_busy,
    output logic       o_frame_done_tick
);

    localparam int unsigned NB       = DATA_BIT / 8;
    localparam int unsigned PACK_NUM = 2 * NB + 1;
    localparam int unsigned CNT_W    = $clog2(DATA_BIT + 1);
    localparam int unsigned IDX_W    = $clog2(DATA_BIT);
    localparam int unsigned BYTE_W   = $clog2(PACK_NUM);
    localparam int unsigned FRAME_W  = 2 * DATA_BIT + 8;

`ifdef DIFF_FREQ_SERIAL_IN_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_BIT-1:0] data_q, data_d;
    logic [DATA_BIT-1:0] speed_q, speed_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [CNT_BIT-1:0]  ivl_q, ivl_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic                close_c;
    logic [FRAME_W-1:0]  frame_c;

    // A saturated interval is never high-speed, whatever the threshold.
    function automatic logic is_high(input logic [CNT_BIT-1:0] ivl);
        return (ivl != '1) && (32'(ivl) <= SPEED_THRESHOLD);
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            speed_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            ivl_q        <= '0;
            byte_idx_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            speed_q      <= speed_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            ivl_q        <= ivl_d;
            byte_idx_q   <= byte_idx_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, capture and send logic; outputs decode the next state.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        speed_d      = speed_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        ivl_d        = ivl_q;
        byte_idx_d   = byte_idx_q;
        frame_done_d = 1'b0;
        close_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_bit_tick) begin
                    data_d[0] = i_serial_in;
                    cnt_d     = CNT_W'(1);
                    ivl_d     = CNT_BIT'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                ivl_d = (ivl_q == '1) ? ivl_q : ivl_q + CNT_BIT'(1);
                if (i_bit_tick) begin
                    // Once overflowed, the last stored bit was already classified.
                    if (!ovf_q) begin
                        speed_d[IDX_W'(cnt_q - CNT_W'(1))] = is_high(ivl_q);
                    end
                    if (cnt_q < CNT_W'(DATA_BIT)) begin
                        data_d[IDX_W'(cnt_q)] = i_serial_in;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    ivl_d = CNT_BIT'(1);
                end
                if (i_done_tick) begin
                    // A same-cycle tick starts a bit whose interval is 1.
                    if (!ovf_d) begin
                        speed_d[IDX_W'(cnt_d - CNT_W'(1))] =
                            is_high(i_bit_tick ? CNT_BIT'(1) : ivl_q);
                    end
                    close_c = 1'b1;
                end else if (TIMEOUT_EN && !i_bit_tick &&
                             (32'(ivl_q) >= TIMEOUT_CYCLES)) begin
                    if (!ovf_q) begin
                        speed_d[IDX_W'(cnt_q - CNT_W'(1))] = 1'b0;
                    end
                    close_c = 1'b1;
                end
                if (close_c) begin
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done_tick) begin
                    if (byte_idx_q == BYTE_W'(PACK_NUM - 1)) begin
                        frame_done_d = 1'b1;
                        data_d       = '0;
                        speed_d      = '0;
                        cnt_d        = '0;
                        ovf_d        = 1'b0;
                        ivl_d        = '0;
                        byte_idx_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        frame_c    = {ovf_d, 7'(cnt_d), speed_d, data_d};
        busy_d     = (state_d == SEND) || (state_d == WAIT_DONE);
        tx_start_d = (state_d == SEND);
        tx_data_d  = tx_start_d ? 8'(frame_c >> {byte_idx_d, 3'b000}) : tx_data_q;
    end

    assign o_tx_data         = tx_data_q;
    assign o_tx_start        = tx_start_q;
    assign o_busy            = busy_q;
    assign o_frame_done_tick = frame_done_q;

endmodule
